// File: rtl/aes_stream_source.sv
// TCDM read streamer for the AES HWPE: fetches trans_size words from base_addr
// and forwards them through a small credit-limited FIFO to the engine stream.
module aes_stream_source #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  req_start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [15:0]           trans_size_i,
  output logic                  ready_start_o,
  output logic                  done_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [3:0]            tcdm_be_o,
  input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [15:0]            rem_req_q, rem_out_q;
  logic [CNT_W-1:0]       outstanding_q, drop_q, fifo_count;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic                   accept, grant, resp_live, push, pop, credit, fifo_empty;

  // Credit: never request more than the FIFO could absorb
  assign fifo_empty = (fifo_count == '0);
  assign credit     = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
  assign tcdm_req_o = (state_q == FETCH) && (rem_req_q != 16'd0) && credit && !clear;
  assign grant      = tcdm_req_o && tcdm_gnt_i;
  assign resp_live  = tcdm_r_valid_i && (drop_q == '0);
  assign push       = resp_live && !clear;
  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i && !clear;
  assign accept     = (state_q == IDLE) && req_start_i && !clear;

  assign tcdm_add_o    = addr_q;
  assign tcdm_wen_o    = 1'b1;
  assign tcdm_be_o     = 4'hF;
  assign data_o        = fifo_empty ? '0 : mem[rd_ptr];
  assign ready_start_o = (state_q == IDLE);
  assign done_o        = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_start_i) state_d = (trans_size_i == 16'd0) ? DONE : FETCH;
      FETCH: if (grant && (rem_req_q == 16'd1)) state_d = DRAIN;
      DRAIN: if (pop && (rem_out_q == 16'd1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Counters, address and FIFO bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      rem_req_q     <= '0;
      rem_out_q     <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else if (clear) begin
      addr_q        <= '0;
      rem_req_q     <= '0;
      rem_out_q     <= '0;
      outstanding_q <= '0;
      fifo_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      // Remember responses still in flight so they are discarded on arrival
      drop_q <= (tcdm_r_valid_i && (outstanding_q != '0)) ? outstanding_q - CNT_W'(1)
                                                           : outstanding_q;
    end else begin
      if (accept) begin
        addr_q    <= base_addr_i;
        rem_req_q <= trans_size_i;
        rem_out_q <= trans_size_i;
      end else begin
        if (grant) begin
          addr_q    <= addr_q + ADDR_WIDTH'(4);
          rem_req_q <= rem_req_q - 16'd1;
        end
        if (pop) rem_out_q <= rem_out_q - 16'd1;
      end
      if (tcdm_r_valid_i && (drop_q != '0)) drop_q <= drop_q - CNT_W'(1);
      case ({grant, resp_live})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tcdm_r_data_i;
  end

  assert property (@(posedge clk) disable iff (!reset_n)
                   !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: doc/aes_stream_source.md
Name: aes_stream_source

Overview:
- Responder side of the streamer control handshake that the AES control FSM drives (req_start, ready_start, done).
- On a request it fetches trans_size 32-bit words from TCDM, starting at base_addr.
- Fetched words go to the AES engine over a valid/ready stream, buffered in a small FIFO.
- Sits between the engine FSM and the cluster TCDM port. It replaces the generic source for the AES HWPE.

Parameters:
- FIFO_DEPTH, 2, number of word entries in the response FIFO; must be at least 2 and a power of 2.
- ADDR_WIDTH, 32, width of the TCDM address.
- DATA_WIDTH, 32, width of the TCDM and stream data; fixed at 32.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear.
- req_start_i  in  1  start request from the FSM.
- base_addr_i  in  ADDR_WIDTH  byte address of the first word; sampled when a request is accepted.
- trans_size_i  in  16  number of words to fetch; sampled when a request is accepted.
- ready_start_o  out  1  block is idle and can accept a request.
- done_o  out  1  one-cycle pulse when the transfer is complete.
- tcdm_req_o  out  1  TCDM read request.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_add_o  out  ADDR_WIDTH  TCDM word address (byte addressed, word aligned).
- tcdm_wen_o  out  1  write enable, active low; tied to 1 (read only).
- tcdm_be_o  out  4  byte enables; constant 4'hF.
- tcdm_r_data_i  in  DATA_WIDTH  read data.
- tcdm_r_valid_i  in  1  read data valid.
- data_o  out  DATA_WIDTH  stream data to the engine.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; FIFO empty; all counters 0.
  - Output values in reset: ready_start_o=1, done_o=0, tcdm_req_o=0, tcdm_add_o=0, valid_o=0, data_o=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - ready_start_o=1.
  - If req_start_i=1: latch addr_q=base_addr_i and rem_req_q=rem_out_q=trans_size_i.
  - If trans_size_i=0, go to DONE; otherwise go to FETCH.
  - ready_start_o=0 in every state other than IDLE.
- Accepted request: req_start_i is ignored in every state except IDLE.
- FETCH:
  - tcdm_req_o = (rem_req_q != 0) && (outstanding_q + fifo_count < FIFO_DEPTH).
  - tcdm_add_o = addr_q.
  - A grant occurs when tcdm_req_o && tcdm_gnt_i. On a grant: addr_q += 4 (wraps modulo 2^ADDR_WIDTH), rem_req_q -= 1, outstanding_q += 1.
  - Once tcdm_req_o is asserted, address and request are held until the grant arrives, unless clear is asserted.
  - When rem_req_q reaches 0 after a grant, go to DRAIN.
- TCDM response:
  - tcdm_r_valid_i arrives exactly 1 cycle after the grant.
  - Each response word is pushed into the FIFO and outstanding_q is decremented.
  - The credit rule in FETCH guarantees the push never finds the FIFO full. A push to a full FIFO is an assertion error.
- Same-cycle events: a grant and a response in the same cycle leave outstanding_q unchanged.
- Stream output:
  - valid_o = FIFO not empty; data_o = FIFO head.
  - A pop occurs on valid_o && ready_i; each pop decrements rem_out_q.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Zero latency from FIFO write to valid_o: a response in cycle N gives valid_o=1 in cycle N+1.
- DRAIN: when rem_out_q reaches 0 after a pop, go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
  - ready_start_o returns to 1 in the cycle after the done_o pulse.
- Minimum latency: for a 1-word request with gnt=1 and ready=1, done_o pulses 4 cycles after the request-accept cycle.
- clear, synchronous, highest priority after reset:
  - State goes to IDLE; FIFO flushed; counters zeroed.
  - tcdm_req_o is dropped in the same cycle as clear (combinational gating).
  - Responses still in flight are discarded while outstanding_q is nonzero.
  - No done_o pulse is generated for the cleared transfer.
- Reset mid-operation: the same effect as clear, but applied asynchronously.

Test Plan:
- Single word: base_addr=0x1000, size=1, gnt=1, ready=1, memory word 0xDEADBEEF.
  - Required: one request with tcdm_add_o=0x1000; data_o=0xDEADBEEF with valid_o; done_o pulses 4 cycles after the request is accepted; ready_start_o=1 on the next cycle.
- Burst of 4 words: base=0x2000, size=4, ready_i=0 for the first 6 cycles, then ready_i=1.
  - Required: no more than 2 words outstanding or buffered while stalled; addresses 0x2000, 0x2004, 0x2008, 0x200C in order; data delivered in order; exactly one done_o pulse.
- Grant stalls: size=3, tcdm_gnt_i low on alternate cycles.
  - Required: tcdm_add_o stable while the request is ungranted; exactly 3 grants; 3 words delivered.
- Zero size: size=0.
  - Required: no tcdm_req_o at any point; done_o pulses 1 cycle after accept; valid_o stays 0.
- Busy request: req_start_i pulsed during FETCH with a different base_addr.
  - Required: the new request is ignored; the original address sequence continues unchanged.
- Clear mid-transfer: size=4, clear asserted after 2 grants, while one response is still in flight.
  - Required: tcdm_req_o=0 in the clear cycle; valid_o=0 afterwards; the late response is dropped; no done_o pulse; ready_start_o=1 on the next cycle.
  - Follow-up: a new request then completes normally.
